inst_fetch_unit: RTL
====================

// Module: inst_fetch_unit
// PURPOSE
//  Fetch stage of the RICPU datapath. Drives the synchronous IROM (1-cycle read latency)
//  and presents one instruction per cycle to decode with a valid/stall handshake.
//  A skid register absorbs decode stalls. A redirect port (branch/jump target) flushes
//  the in-flight fetch. Replaces the free-running PC in the fetch path.
// PARAMETERS
//  ADDR_W    6      IROM word-address width; irom_addra = fetch_pc[ADDR_W+1:2]
//  RESET_PC  32'h0  PC loaded on reset; bits [1:0] must be 0
// PORTS
//  clka           in   1       clock; all state updates on posedge
//  rst            in   1       asynchronous, active-high reset
//  stall          in   1       decode cannot accept inst_code this cycle
//  redirect_valid in   1       load redirect_pc as next fetch address; flush in-flight fetch
//  redirect_pc    in   32      target byte address; bits [1:0] forced to 0
//  irom_addra     out  ADDR_W  IROM word address (combinational from fetch_pc)
//  irom_douta     in   32      IROM data; word at address sampled on previous edge
//  inst_valid     out  1       inst_code/inst_pc hold a real instruction
//  inst_code      out  32      instruction; 0 when inst_valid=0
//  inst_pc        out  32      byte address of inst_code
//  pc_plus4       out  32      inst_pc + 4 (combinational, mod 2^32)
//  inst_count     out  32      instructions accepted by decode, wraps mod 2^32
// BEHAVIOUR
//  Registers: fetch_pc[31:0], inst_pc, skid[31:0], inst_count, state in {FILL,RUN,HOLD}.
//  Reset (async, immediate): fetch_pc=RESET_PC, state=FILL, inst_pc=0, skid=0, inst_count=0.
//   Outputs: inst_valid=0, inst_code=0, pc_plus4=4.
//  Outputs by state: FILL: inst_valid=0, inst_code=0. RUN: inst_valid=1, inst_code=irom_douta.
//   HOLD: inst_valid=1, inst_code=skid.
//  "accept" = inst_valid & ~stall at a posedge. On accept, inst_count += 1.
//   This applies even when redirect_valid is high in the same cycle.
//  Transitions at posedge clka, evaluated in priority order:
//   1 redirect_valid (any state): fetch_pc<={redirect_pc[31:2],2'b00}; state<=FILL.
//     skid and inst_pc unchanged. The fetch in flight is discarded.
//   2 FILL: inst_pc<=fetch_pc; fetch_pc<=fetch_pc+4; ->RUN. stall ignored.
//   3 RUN & ~stall: inst_pc<=fetch_pc; fetch_pc<=fetch_pc+4; stay RUN.
//   4 RUN & stall: skid<=irom_douta; fetch_pc, inst_pc held; ->HOLD.
//   5 HOLD & stall: all held.
//   6 HOLD & ~stall: inst_pc<=fetch_pc; fetch_pc<=fetch_pc+4; ->RUN.
//  Latency:
//   First valid instruction appears 2 edges after rst deassert (FILL edge, then data).
//   Redirect costs exactly 1 bubble cycle (inst_valid=0) before the target appears.
//  While stalled, the IROM keeps re-reading fetch_pc, so exiting HOLD needs no refetch.
//  Wrap-around:
//   fetch_pc wraps mod 2^32.
//   irom_addra wraps mod 2^ADDR_W words (0xFC -> 0x100 maps word 63 -> word 0).
//  No combinational path from stall or redirect_* to any output except through state.
// TESTING
//  T1 IROM[0]=0x20010005, IROM[1]=0x20020003; release rst, stall=0 ->
//     edge1: inst_valid=0; edge2: valid, pc=0, code=0x20010005;
//     edge3: pc=4, code=0x20020003, pc_plus4=8.
//  T2 stall=1 for 3 cycles while inst_pc=8 ->
//     code/pc held (pc=8), inst_count constant;
//     first cycle after release still shows pc=8; next shows pc=0xC, count+1.
//  T3 redirect_valid=1, redirect_pc=0x23 at pc=4 ->
//     pc=4 accepted (count+1); one bubble; then inst_pc=0x20, code=IROM[8].
//  T4 in HOLD, stall=1 and redirect_valid=1 (pc=0x40) together ->
//     skid discarded, bubble, then inst_pc=0x40; no accept counted.
//  T5 ADDR_W=6, redirect to 0xFC ->
//     inst_pc=0xFC (IROM[63]), then inst_pc=0x100 with code=IROM[0], irom_addra=0.
//  T6 rst pulsed between edges mid-run ->
//     inst_valid=0, inst_count=0, irom_addra=0 before next edge;
//     fetch restarts per T1.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//   Fetch stage of the RICPU datapath. Drives a synchronous IROM with a
//   one-cycle read latency and presents one instruction per cycle to decode
//   over a valid/stall handshake. A skid register holds the current
//   instruction while decode stalls. A redirect (branch/jump target) discards
//   the fetch in flight and costs exactly one bubble cycle.
//
// Ports
//   clka           in   1       clock, all state updates on posedge
//   rst            in   1       asynchronous, active-high reset
//   stall          in   1       decode cannot accept inst_code this cycle
//   redirect_valid in   1       load redirect_pc as next fetch address
//   redirect_pc    in   32      target byte address (bits [1:0] ignored)
//   irom_addra     out  ADDR_W  IROM word address, from fetch_pc
//   irom_douta     in   32      IROM data for the address sampled last edge
//   inst_valid     out  1       inst_code/inst_pc hold a real instruction
//   inst_code      out  32      instruction, 0 when inst_valid is low
//   inst_pc        out  32      byte address of inst_code
//   pc_plus4       out  32      inst_pc + 4 (mod 2^32)
//   inst_count     out  32      instructions accepted by decode (wraps)
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] irom_addra,
  input  logic [31:0]       irom_douta,
  output logic              inst_valid,
  output logic [31:0]       inst_code,
  output logic [31:0]       inst_pc,
  output logic [31:0]       pc_plus4,
  output logic [31:0]       inst_count
);

  // FILL: IROM read in flight, nothing to present yet.
  // RUN : IROM output is the instruction at inst_pc.
  // HOLD: decode stalled; the instruction lives in the skid register while
  //       the IROM already re-reads fetch_pc (the next instruction).
  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_inst_pc;
  logic [31:0] r_skid;
  logic [31:0] r_inst_count;

  logic [1:0]  w_state_nxt;
  logic [31:0] w_fetch_pc_nxt;
  logic [31:0] w_inst_pc_nxt;
  logic [31:0] w_skid_nxt;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_code;
  logic        w_valid;
  logic        w_accept;

  assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;
  assign w_valid       = (r_state == ST_RUN) || (r_state == ST_HOLD);
  assign w_accept      = w_valid & ~stall;

  // Next-state and next-register selection, redirect has top priority.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_inst_pc_nxt  = r_inst_pc;
    w_skid_nxt     = r_skid;
    if (redirect_valid) begin
      w_fetch_pc_nxt = w_redirect_pc;
      w_state_nxt    = ST_FILL;
    end else begin
      case (r_state)
        ST_FILL: begin
          w_inst_pc_nxt  = r_fetch_pc;
          w_fetch_pc_nxt = r_fetch_pc + 32'd4;
          w_state_nxt    = ST_RUN;
        end
        ST_RUN: begin
          if (stall) begin
            w_skid_nxt  = irom_douta;
            w_state_nxt = ST_HOLD;
          end else begin
            w_inst_pc_nxt  = r_fetch_pc;
            w_fetch_pc_nxt = r_fetch_pc + 32'd4;
            w_state_nxt    = ST_RUN;
          end
        end
        ST_HOLD: begin
          // IROM has been re-reading fetch_pc, so leaving HOLD needs no refetch.
          if (stall) begin
            w_state_nxt = ST_HOLD;
          end else begin
            w_inst_pc_nxt  = r_fetch_pc;
            w_fetch_pc_nxt = r_fetch_pc + 32'd4;
            w_state_nxt    = ST_RUN;
          end
        end
        default: begin
          w_state_nxt = ST_FILL;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      r_state      <= ST_FILL;
      r_fetch_pc   <= RESET_PC;
      r_inst_pc    <= 32'd0;
      r_skid       <= 32'd0;
      r_inst_count <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_inst_pc  <= w_inst_pc_nxt;
      r_skid     <= w_skid_nxt;
      // Accept is counted even when a redirect lands in the same cycle.
      if (w_accept) begin
        r_inst_count <= r_inst_count + 32'd1;
      end else begin
        r_inst_count <= r_inst_count;
      end
    end
  end

  // Instruction mux: live IROM data in RUN, skid copy in HOLD, zero otherwise.
  always_comb begin
    w_code = 32'd0;
    case (r_state)
      ST_RUN:  w_code = irom_douta;
      ST_HOLD: w_code = r_skid;
      default: w_code = 32'd0;
    endcase
  end

  assign irom_addra = r_fetch_pc[ADDR_W+1:2];
  assign inst_valid = w_valid;
  assign inst_code  = w_code;
  assign inst_pc    = r_inst_pc;
  assign pc_plus4   = r_inst_pc + 32'd4;
  assign inst_count = r_inst_count;

endmodule
